// File: rtl/line_cmd_scheduler.sv
// line_cmd_scheduler
// Command sequencer for the oblique line-drawing engine. Line-segment
// commands from the drawing front-end are queued in a small FIFO. Each one
// is normalised so that it runs left-to-right, loaded onto the engine
// coordinate outputs and started with a one-cycle pulse. The sequencer then
// waits for the engine to report completion, under a watchdog.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-low reset (0 = reset)
//   flush        empties the FIFO and abandons the current draw
//   cmd_valid    command offer from the front-end
//   cmd_ready    FIFO can accept a command (count < DEPTH)
//   cmd_x0/y0    segment start point
//   cmd_x1/y1    segment end point
//   x_offset/y_offset/x_final/y_final   normalised engine coordinates
//   start_mark   one-cycle engine start pulse
//   done_mark    engine completion (level or pulse), sampled only in WAIT
//   busy         sequencer active or FIFO non-empty
//   fifo_count   FIFO occupancy
//   lines_done   completed-line counter (wraps)
//   timeout_err  sticky watchdog flag
//   clear_err    clears timeout_err
module line_cmd_scheduler #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [10:0]                cmd_x0,
  input  logic [9:0]                 cmd_y0,
  input  logic [10:0]                cmd_x1,
  input  logic [9:0]                 cmd_y1,
  output logic [10:0]                x_offset,
  output logic [9:0]                 y_offset,
  output logic [10:0]                x_final,
  output logic [9:0]                 y_final,
  output logic                       start_mark,
  input  logic                       done_mark,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                lines_done,
  output logic                       timeout_err,
  input  logic                       clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t          state_r;
  logic [41:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [WW-1:0]   wdog_r;

  logic            push_s;
  logic            pop_s;
  logic            done_s;
  logic            timeout_s;
  logic [41:0]     head_s;
  logic [10:0]     norm_x0_s;
  logic [9:0]      norm_y0_s;
  logic [10:0]     norm_x1_s;
  logic [9:0]      norm_y1_s;

  // Handshake and status are combinational from the occupancy and state.
  assign cmd_ready  = (count_r < FULL_COUNT);
  assign busy       = (state_r != IDLE) || (count_r != {CW{1'b0}});
  assign fifo_count = count_r;

  // A push in a flush cycle is discarded; the head is only consumed in LOAD.
  assign push_s    = cmd_valid && cmd_ready && !flush;
  assign pop_s     = (state_r == LOAD) && !flush;
  // Completion beats a watchdog expiry landing on the same cycle.
  assign done_s    = (state_r == WAIT) && done_mark && !flush;
  assign timeout_s = (state_r == WAIT) && !done_mark && !flush && (wdog_r == WD_LAST);

  assign head_s = mem_r[rd_ptr_r];

  // Normalise the head command so the engine always draws left-to-right.
  always_comb begin
    norm_x0_s = head_s[41:31];
    norm_y0_s = head_s[30:21];
    norm_x1_s = head_s[20:10];
    norm_y1_s = head_s[9:0];
    if (head_s[20:10] < head_s[41:31]) begin
      norm_x0_s = head_s[20:10];
      norm_y0_s = head_s[9:0];
      norm_x1_s = head_s[41:31];
      norm_y1_s = head_s[30:21];
    end else begin
      norm_x0_s = head_s[41:31];
      norm_y0_s = head_s[30:21];
      norm_x1_s = head_s[20:10];
      norm_y1_s = head_s[9:0];
    end
  end

  // Command storage; entries are kept exactly as offered.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_r[wr_ptr_r] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencer FSM with registered engine outputs, watchdog and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      x_offset    <= 11'd0;
      y_offset    <= 10'd0;
      x_final     <= 11'd0;
      y_final     <= 10'd0;
      start_mark  <= 1'b0;
      wdog_r      <= {WW{1'b0}};
      lines_done  <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      if (flush) begin
        // Coordinates deliberately hold their last values.
        state_r    <= IDLE;
        start_mark <= 1'b0;
        wdog_r     <= {WW{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            start_mark <= 1'b0;
            if (count_r != {CW{1'b0}}) begin
              state_r <= LOAD;
            end
          end
          LOAD: begin
            x_offset   <= norm_x0_s;
            y_offset   <= norm_y0_s;
            x_final    <= norm_x1_s;
            y_final    <= norm_y1_s;
            // Raised here so the pulse coincides with the START cycle.
            start_mark <= 1'b1;
            state_r    <= START;
          end
          START: begin
            start_mark <= 1'b0;
            wdog_r     <= {WW{1'b0}};
            state_r    <= WAIT;
          end
          WAIT: begin
            start_mark <= 1'b0;
            if (done_s || timeout_s) begin
              state_r <= IDLE;
            end else begin
              wdog_r <= wdog_r + WW'(1);
            end
          end
          default: begin
            start_mark <= 1'b0;
            state_r    <= IDLE;
          end
        endcase
      end

      if (done_s) begin
        lines_done <= lines_done + 16'd1;
      end

      // A watchdog expiry in the same cycle as clear_err keeps the flag set.
      if (timeout_s) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
